// File: rtl/traffic_monitor_if.sv
// Observation bus between the four-direction light controller and the monitor.
// The controller side (master) drives the light codes; the monitor (slave) reports errors.
interface traffic_monitor_if;
  logic       i_start;
  logic       i_clear;
  logic [3:0] i_e_ct, i_w_ct, i_s_ct, i_n_ct;
  logic [1:0] i_e_wt, i_w_wt, i_s_wt, i_n_wt;
  logic [4:0] o_err_flags;
  logic [3:0] o_err_dir;
  logic       o_err_valid;
  logic [2:0] o_first_err;
  logic [7:0] o_cycle_cnt;

  modport master (
    output i_start, i_clear,
    output i_e_ct, i_w_ct, i_s_ct, i_n_ct,
    output i_e_wt, i_w_wt, i_s_wt, i_n_wt,
    input  o_err_flags, o_err_dir, o_err_valid, o_first_err, o_cycle_cnt
  );

  modport slave (
    input  i_start, i_clear,
    input  i_e_ct, i_w_ct, i_s_ct, i_n_ct,
    input  i_e_wt, i_w_wt, i_s_wt, i_n_wt,
    output o_err_flags, o_err_dir, o_err_valid, o_first_err, o_cycle_cnt
  );
endinterface

// File: rtl/traffic_monitor.sv
// Receive-side checker for four-direction traffic light outputs: per-direction
// encoding/transition/dwell checks plus cross-group conflict and sticky error capture.

module tm_dir_chk #(
  parameter int P_MIN_YELLOW = 2,
  parameter int P_MAX_DWELL  = 80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] ct,
  input  logic [1:0] wt,
  output logic       enc_err,
  output logic       tr_err,
  output logic       short_yel,
  output logic       stall,
  output logic       go,
  output logic       red_to_grn
);
  localparam logic [3:0] C_NONE   = 4'b0000;
  localparam logic [3:0] C_GREEN  = 4'b0001;
  localparam logic [3:0] C_LEFT   = 4'b0010;
  localparam logic [3:0] C_YELLOW = 4'b0100;
  localparam logic [3:0] C_RED    = 4'b1000;
  localparam logic [1:0] W_NONE   = 2'b00;
  localparam logic [1:0] W_GREEN  = 2'b01;
  localparam logic [1:0] W_RED    = 2'b10;
  localparam logic [1:0] W_BAD    = 2'b11;
  localparam logic [7:0] MIN_YEL  = 8'(P_MIN_YELLOW);
  localparam logic [7:0] STALL_AT = 8'(P_MAX_DWELL - 1);

  logic [3:0] prev_ct;
  logic [1:0] prev_wt;
  logic [7:0] dwell;
  logic       car_bad, prev_car_bad, wk_bad, chg;

  function automatic logic car_ok(input logic [3:0] c);
    return c inside {C_NONE, C_GREEN, C_LEFT, C_YELLOW, C_RED};
  endfunction

  function automatic logic car_step_ok(input logic [3:0] p, input logic [3:0] c);
    if (p == c) return 1'b1;
    case ({p, c})
      {C_NONE, C_GREEN}, {C_NONE, C_RED}, {C_GREEN, C_YELLOW},
      {C_YELLOW, C_LEFT}, {C_YELLOW, C_RED}, {C_LEFT, C_YELLOW},
      {C_RED, C_GREEN}: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic wk_step_ok(input logic [1:0] p, input logic [1:0] c);
    if (p == c) return 1'b1;
    case ({p, c})
      {W_NONE, W_RED}, {W_NONE, W_GREEN}, {W_RED, W_GREEN},
      {W_GREEN, W_RED}, {W_GREEN, W_NONE}: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  always_comb begin
    car_bad      = !car_ok(ct);
    prev_car_bad = !car_ok(prev_ct);
    wk_bad       = (wt == W_BAD);
    chg          = (ct != prev_ct);
    enc_err      = car_bad | wk_bad;
    // An illegal code on either side of the step already reports as an encoding fault.
    tr_err       = (!car_bad && !prev_car_bad && !car_step_ok(prev_ct, ct)) ||
                   (!wk_bad && (prev_wt != W_BAD) && !wk_step_ok(prev_wt, wt));
    short_yel    = (prev_ct == C_YELLOW) && chg && (dwell < MIN_YEL);
    // Fires on the edge the counter steps onto the limit, so once per dwell.
    stall        = start && !chg && (ct != C_NONE) && (dwell == STALL_AT);
    go           = (ct == C_GREEN) || (ct == C_LEFT);
    red_to_grn   = (prev_ct == C_RED) && (ct == C_GREEN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_ct <= C_NONE;
      prev_wt <= W_NONE;
      dwell   <= '0;
    end else begin
      prev_ct <= ct;
      prev_wt <= wt;
      if (chg)                          dwell <= 8'd1;
      else if (start && dwell != 8'hff) dwell <= dwell + 8'd1;
    end
  end
endmodule

module traffic_monitor #(
  parameter int P_MIN_YELLOW = 2,
  parameter int P_MAX_DWELL  = 80
) (
  input logic               clk,
  input logic               reset,
  traffic_monitor_if.slave  mon
);
  localparam int NUM_DIR = 4;

  // Direction order {N,S,W,E}: index 0 = E, matching the o_err_dir bit order.
  logic [NUM_DIR-1:0][3:0] ct;
  logic [NUM_DIR-1:0][1:0] wt;
  logic [NUM_DIR-1:0]      enc_err, tr_err, short_yel, stall, go, red_to_grn;

  logic [4:0] new_flags, err_flags, keep_flags;
  logic [3:0] new_dir, err_dir, keep_dir;
  logic       conflict, any_new, err_valid, keep_valid;
  logic [2:0] first_code, first_err;
  logic [7:0] cycle_cnt;

  assign ct = {mon.i_n_ct, mon.i_s_ct, mon.i_w_ct, mon.i_e_ct};
  assign wt = {mon.i_n_wt, mon.i_s_wt, mon.i_w_wt, mon.i_e_wt};

  for (genvar g = 0; g < NUM_DIR; g++) begin : g_dir
    tm_dir_chk #(
      .P_MIN_YELLOW (P_MIN_YELLOW),
      .P_MAX_DWELL  (P_MAX_DWELL)
    ) u_dir (
      .clk        (clk),
      .reset      (reset),
      .start      (mon.i_start),
      .ct         (ct[g]),
      .wt         (wt[g]),
      .enc_err    (enc_err[g]),
      .tr_err     (tr_err[g]),
      .short_yel  (short_yel[g]),
      .stall      (stall[g]),
      .go         (go[g]),
      .red_to_grn (red_to_grn[g])
    );
  end

  always_comb begin
    // Group A = {E,S} (bits 0,2), group B = {W,N} (bits 1,3).
    conflict  = (go[0] | go[2]) & (go[1] | go[3]);
    new_flags = {|stall, |short_yel, conflict, |tr_err, |enc_err};
    new_dir   = enc_err | tr_err | short_yel | stall | (conflict ? go : 4'b0000);
    any_new   = |new_flags;
    first_code = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (new_flags[i]) first_code = 3'(i);
    // A clear in the same cycle as a new error acts as if it happened just before it.
    keep_flags = mon.i_clear ? 5'b0 : err_flags;
    keep_dir   = mon.i_clear ? 4'b0 : err_dir;
    keep_valid = mon.i_clear ? 1'b0 : err_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flags <= '0;
      err_dir   <= '0;
      err_valid <= 1'b0;
      first_err <= '0;
      cycle_cnt <= '0;
    end else begin
      err_flags <= keep_flags | new_flags;
      err_dir   <= keep_dir | new_dir;
      err_valid <= keep_valid | any_new;
      if (!keep_valid && any_new) first_err <= first_code;
      else if (mon.i_clear)       first_err <= '0;
      cycle_cnt <= cycle_cnt + 8'(red_to_grn[0]);
    end
  end

  assign mon.o_err_flags = err_flags;
  assign mon.o_err_dir   = err_dir;
  assign mon.o_err_valid = err_valid;
  assign mon.o_first_err = first_err;
  assign mon.o_cycle_cnt = cycle_cnt;
endmodule
